trivium_rx: RTL and testbench

Receive-side Trivium stream-cipher block: loads an 80-bit key and 80-bit IV, runs the 1152-round warm-up, then XORs each accepted serial ciphertext bit with one keystream bit and packs the recovered plaintext MSB-first into bytes. It is the decrypting end of the serial keystream link, fed by the link deserializer and driving the byte sink through a valid/ready handshake. One cipher round is consumed per accepted bit; the cipher state never advances while stalled.

---
 rtl/trivium_rx_if.sv | 27 ++
 rtl/trivium_rx.sv | 131 +++++++++++++
 tb/tb_trivium_rx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/trivium_rx_if.sv
// Handshake and key-load bundle between the link deserializer, trivium_rx and the byte sink.
// The slave modport is the cipher block. The master modport is the driving side.
interface trivium_rx_if;
  logic        start;
  logic [79:0] key;
  logic [79:0] iv;
  logic        in_valid;
  logic        in_bit;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [3:0]  out_nbits;
  logic        out_ready;
  logic        busy;

  modport master (
    output start, key, iv, in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_byte, out_last, out_nbits, busy
  );

  modport slave (
    input  start, key, iv, in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_byte, out_last, out_nbits, busy
  );
endinterface

// File: rtl/trivium_rx.sv
// Trivium receive path: key/IV load and warm-up, then one keystream bit per accepted
// ciphertext bit. Recovered plaintext is packed MSB-first into bytes.
module trivium_rx #(
  parameter int unsigned INIT_ROUNDS = 1152
) (
  input  logic         clk,
  input  logic         rst,
  trivium_rx_if.slave  bus
);
  localparam int unsigned STATE_W = 288;
  localparam int unsigned CNT_W   = $clog2(INIT_ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN} state_t;

  // Bit k of r_s holds cipher state bit s(k+1).
  logic [STATE_W-1:0] r_s;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_acc;
  logic [2:0]         r_nb;
  logic               r_out_valid;
  logic [7:0]         r_out_byte;
  logic               r_out_last;
  logic [3:0]         r_out_nbits;
  logic               r_busy;

  logic               w_t1, w_t2, w_t3, w_z;
  logic [STATE_W-1:0] w_round;
  logic [STATE_W-1:0] w_load;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_pbit;
  logic [7:0]         w_acc_next;
  logic               w_flush;
  logic               w_drain;

  // One Trivium round: keystream bit z and the shifted state.
  assign w_z  = r_s[65] ^ r_s[92] ^ r_s[161] ^ r_s[176] ^ r_s[242] ^ r_s[287];
  assign w_t1 = r_s[65]  ^ r_s[92]  ^ (r_s[90]  & r_s[91])  ^ r_s[170];
  assign w_t2 = r_s[161] ^ r_s[176] ^ (r_s[174] & r_s[175]) ^ r_s[263];
  assign w_t3 = r_s[242] ^ r_s[287] ^ (r_s[285] & r_s[286]) ^ r_s[68];
  assign w_round = {r_s[286:177], w_t2, r_s[175:93], w_t1, r_s[91:0], w_t3};

  assign w_load = {3'b111, 108'd0, 4'd0, bus.iv, 13'd0, bus.key};

  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready && !bus.start;
  assign w_pbit     = bus.in_bit ^ w_z;
  assign w_acc_next = r_acc | (8'(w_pbit) << (3'd7 - r_nb));
  assign w_flush    = w_accept && ((r_nb == 3'd7) || bus.in_last);
  assign w_drain    = r_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s         <= '0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_nb        <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= '0;
      r_out_last  <= 1'b0;
      r_out_nbits <= '0;
      r_busy      <= 1'b0;
    end else if (bus.start) begin
      // A start in any state reloads the cipher and discards any partial or pending output.
      r_s         <= w_load;
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_nb        <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= '0;
      r_out_last  <= 1'b0;
      r_out_nbits <= '0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
        end
        S_INIT: begin
          r_s   <= w_round;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(INIT_ROUNDS - 1)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_drain) begin
            r_out_valid <= 1'b0;
          end
          if (w_accept) begin
            r_s <= w_round;
            if (w_flush) begin
              r_out_valid <= 1'b1;
              r_out_byte  <= w_acc_next;
              r_out_nbits <= 4'(r_nb) + 4'd1;
              r_out_last  <= bus.in_last;
              r_acc       <= '0;
              r_nb        <= '0;
            end else begin
              r_acc <= w_acc_next;
              r_nb  <= r_nb + 3'd1;
            end
            if (bus.in_last) begin
              r_state <= S_DRAIN;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_byte  = r_out_byte;
  assign bus.out_last  = r_out_last;
  assign bus.out_nbits = r_out_nbits;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_trivium_rx.sv
// Bench for trivium_rx: a bit-array Trivium model produces the ciphertext and the
// expected plaintext bytes, with randomized valid/ready traffic and scripted corner cases.
module tb_trivium_rx;
  localparam int unsigned INIT_ROUNDS = 1152;
  localparam logic [79:0] K1 = 80'h0123456789ABCDEF0123;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trivium_rx_if bus ();
  trivium_rx #(.INIT_ROUNDS(INIT_ROUNDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  bit m_s [1:288];
  bit ks [$];
  bit pt [$];
  bit rt_ks0 [$];
  int last_acc_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_load(input logic [79:0] k, input logic [79:0] v);
    for (int i = 1; i <= 288; i++) m_s[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      m_s[i + 1]  = k[i];
      m_s[94 + i] = v[i];
    end
    m_s[286] = 1'b1;
    m_s[287] = 1'b1;
    m_s[288] = 1'b1;
  endtask

  task automatic m_round(output bit z);
    bit t1, t2, t3;
    t1 = m_s[66] ^ m_s[93];
    t2 = m_s[162] ^ m_s[177];
    t3 = m_s[243] ^ m_s[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m_s[91] & m_s[92]) ^ m_s[171];
    t2 = t2 ^ (m_s[175] & m_s[176]) ^ m_s[264];
    t3 = t3 ^ (m_s[286] & m_s[287]) ^ m_s[69];
    for (int i = 93; i >= 2; i--) m_s[i] = m_s[i - 1];
    m_s[1] = t3;
    for (int i = 177; i >= 95; i--) m_s[i] = m_s[i - 1];
    m_s[94] = t1;
    for (int i = 288; i >= 179; i--) m_s[i] = m_s[i - 1];
    m_s[178] = t2;
  endtask

  // Pulse start (with in_valid high to show start wins), then measure the warm-up.
  task automatic do_start(input logic [79:0] k, input logic [79:0] v);
    int w;
    bit z;
    @(negedge clk);
    bus.start = 1'b1; bus.key = k; bus.iv = v;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b0;
    bus.key = 80'({$urandom, $urandom, $urandom});
    bus.iv  = 80'({$urandom, $urandom, $urandom});
    chk("busy_after_start", bus.busy, 1);
    chk("ov_after_start", bus.out_valid, 0);
    w = 0;
    while (!bus.in_ready && w < 2000) begin
      w++;
      @(negedge clk);
    end
    chk("warmup_cycles", w, INIT_ROUNDS);
    m_load(k, v);
    repeat (INIT_ROUNDS) m_round(z);
  endtask

  // Stream pt through the DUT from RUN; compares handshake and bytes every cycle.
  task automatic run_msg(input int stall_at, input int stall_len, input int vprob, input int rprob);
    int nbits, idx, cyc;
    bit ov, run, iv_, rdy, exp_ir, acc, z;
    logic [7:0] eb [$];
    logic [3:0] en [$];
    bit el [$];
    nbits = pt.size();
    ks.delete();
    for (int i = 0; i < nbits; i++) begin
      m_round(z);
      ks.push_back(z);
    end
    for (int b = 0; b < nbits; b += 8) begin
      int n;
      logic [7:0] v;
      n = (nbits - b < 8) ? nbits - b : 8;
      v = '0;
      for (int j = 0; j < n; j++) v[7 - j] = pt[b + j];
      eb.push_back(v);
      en.push_back(4'(n));
      el.push_back(b + 8 >= nbits);
    end
    idx = 0; cyc = 0; ov = 0; run = 1; last_acc_cyc = -1;
    while ((run || ov) && cyc < 5000) begin
      iv_ = run && (idx < nbits) && ($urandom_range(99) < vprob);
      bus.in_valid = iv_;
      bus.in_bit   = (idx < nbits) ? (pt[idx] ^ ks[idx]) : 1'($urandom);
      bus.in_last  = (idx == nbits - 1);
      rdy = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0 : ($urandom_range(99) < rprob);
      bus.out_ready = rdy;
      #1;
      exp_ir = run && (!ov || rdy);
      chk("in_ready", bus.in_ready, exp_ir);
      chk("out_valid", bus.out_valid, ov);
      chk("busy", bus.busy, run);
      if (ov && rdy && eb.size() > 0) begin
        chk("out_byte", bus.out_byte, eb.pop_front());
        chk("out_nbits", bus.out_nbits, en.pop_front());
        chk("out_last", bus.out_last, el.pop_front());
      end
      acc = iv_ && exp_ir;
      if (acc && ((idx % 8 == 7) || idx == nbits - 1)) ov = 1;
      else if (ov && rdy) ov = 0;
      if (acc) begin
        if (idx == nbits - 1) run = 0;
        idx++;
        last_acc_cyc = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    chk("msg_timeout", cyc < 5000, 1);
    chk("bytes_left", eb.size(), 0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    chk("idle_in_ready", bus.in_ready, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_out_valid", bus.out_valid, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic set_pt_bytes(input logic [7:0] b0, input logic [7:0] b1);
    pt.delete();
    for (int j = 7; j >= 0; j--) pt.push_back(b0[j]);
    for (int j = 7; j >= 0; j--) pt.push_back(b1[j]);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b1; bus.key = K1; bus.iv = '0;
    bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.in_last = 1'b0; bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_byte", bus.out_byte, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_nbits", bus.out_nbits, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_in_ready0", bus.in_ready, 0);
    chk("idle_busy0", bus.busy, 0);
    chk("idle_out_valid0", bus.out_valid, 0);
    bus.in_valid = 1'b0;

    // Warm-up length with an all-zero key and IV.
    do_start('0, '0);

    // Continuous round trip, one bit per clock.
    do_start(K1, '0);
    for (int i = 1; i <= 288; i++) ;
    set_pt_bytes(8'hA5, 8'h3C);
    run_msg(-1, 0, 100, 100);
    chk("rt_throughput", last_acc_cyc, 15);
    rt_ks0.delete();
    for (int i = 0; i < 8; i++) rt_ks0.push_back(ks[i]);

    // Sink stalls for 20 cycles right after the first byte completes.
    do_start(K1, 80'h1);
    pt.delete();
    for (int i = 0; i < 32; i++) pt.push_back(1'($urandom));
    run_msg(8, 20, 100, 100);

    // Partial final byte of 3 bits.
    do_start(80'({$urandom, $urandom, $urandom}), 80'({$urandom, $urandom, $urandom}));
    pt.delete();
    for (int i = 0; i < 11; i++) pt.push_back(1'($urandom));
    run_msg(-1, 0, 70, 60);

    // Abort after 5 bits; the restarted keystream begins again from its first bit.
    do_start(K1, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_bit = 1'($urandom); bus.in_last = 1'b0;
      @(negedge clk);
    end
    do_start(K1, '0);
    pt.delete();
    for (int i = 0; i < 8; i++) pt.push_back(rt_ks0[i]);
    run_msg(-1, 0, 100, 100);
    for (int i = 0; i < 8; i++) chk("abort_ct_zero", pt[i] ^ ks[i], 0);

    // Random keys, lengths and traffic.
    for (int m = 0; m < 4; m++) begin
      int len;
      do_start(80'({$urandom, $urandom, $urandom}), 80'({$urandom, $urandom, $urandom}));
      len = $urandom_range(40, 1);
      pt.delete();
      for (int i = 0; i < len; i++) pt.push_back(1'($urandom));
      run_msg(int'($urandom_range(20)), int'($urandom_range(10)),
              int'($urandom_range(100, 50)), int'($urandom_range(100, 40)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
